// File: rtl/ec_defs_pkg.sv
// Shared definitions for the accumulator processor.
// Holds the opcode encodings, the controller state encodings and the A-register
// source-select encodings. The datapath, the controller and the bench all use it.
package ec_defs;

  // Opcode field IR[7:5]
  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // Execute states sit at 8 + opcode so decode is a plain concatenation.
  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd8,
    S_STORE  = 4'd9,
    S_ADD    = 4'd10,
    S_SUB    = 4'd11,
    S_INPUT  = 4'd12,
    S_JZ     = 4'd13,
    S_JPOS   = 4'd14,
    S_HALT   = 4'd15
  } state_t;

  // Accumulator source select
  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Execute state for a given opcode.
  function automatic state_t exec_state(input logic [2:0] op);
    return state_t'({1'b1, op});
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a synchronous level input (key press).
// Ports:
//   clk   - system clock
//   clear - synchronous active-high clear of the history register
//   d     - level input
//   pulse - d & ~q, high for the first cycle d is seen high after being low
module edge_detect (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic pulse
);

  logic q;

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign pulse = d & ~q;

endmodule

// File: rtl/control_unit.sv
// Finite-state controller for the accumulator processor.
// Sequences fetch / decode / execute, waits on the Enter key for INPUT and parks
// in HALT until clear.
// Ports:
//   clk, clear     - clock and synchronous active-high reset
//   IR75           - opcode field from the instruction register
//   Aeq0, Apos     - accumulator status flags (zero, strictly positive)
//   Enter          - user key, synchronous level
//   IRload, PCload, IMPsel, MeminstSel, MemWr, Aload, Asel, ALUsub - datapath controls
//   Halt           - processor halted
//   State          - current state encoding, for debug
module control_unit
  import ec_defs::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] IR75,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       IRload,
  output logic       PCload,
  output logic       IMPsel,
  output logic       MeminstSel,
  output logic       MemWr,
  output logic       Aload,
  output logic [1:0] Asel,
  output logic       ALUsub,
  output logic       Halt,
  output logic [3:0] State
);

  state_t state_q, state_d;
  logic   enter_pulse;

  edge_detect u_enter_edge (
    .clk   (clk),
    .clear (clear),
    .d     (Enter),
    .pulse (enter_pulse)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    IRload     = 1'b0;
    PCload     = 1'b0;
    IMPsel     = 1'b0;
    MeminstSel = 1'b0;
    MemWr      = 1'b0;
    Aload      = 1'b0;
    Asel       = ASEL_ALU;
    ALUsub     = 1'b0;
    Halt       = 1'b0;

    case (state_q)
      S_START: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        IRload  = 1'b1;
        PCload  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Present the operand address a cycle early for the execute state.
        MeminstSel = 1'b1;
        state_d    = exec_state(IR75);
      end
      S_LOAD: begin
        MeminstSel = 1'b1;
        Asel       = ASEL_MEM;
        Aload      = 1'b1;
        state_d    = S_FETCH;
      end
      S_STORE: begin
        MeminstSel = 1'b1;
        MemWr      = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADD: begin
        MeminstSel = 1'b1;
        Aload      = 1'b1;
        state_d    = S_FETCH;
      end
      S_SUB: begin
        MeminstSel = 1'b1;
        ALUsub     = 1'b1;
        Aload      = 1'b1;
        state_d    = S_FETCH;
      end
      S_INPUT: begin
        Asel = ASEL_IN;
        // Mealy load on the key edge; a concurrent clear suppresses it.
        if (enter_pulse && !clear) begin
          Aload   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_JZ: begin
        IMPsel  = 1'b1;
        PCload  = Aeq0;
        state_d = S_FETCH;
      end
      S_JPOS: begin
        IMPsel  = 1'b1;
        PCload  = Apos;
        state_d = S_FETCH;
      end
      S_HALT: begin
        Halt = 1'b1;
      end
      default: begin
        state_d = S_START;
      end
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  import ec_defs::*;

  logic       clk = 1'b0;
  logic       clear;
  logic [2:0] IR75;
  logic       Aeq0, Apos, Enter;
  logic       IRload, PCload, IMPsel, MeminstSel, MemWr, Aload, ALUsub, Halt;
  logic [1:0] Asel;
  logic [3:0] State;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  control_unit dut (
    .clk        (clk),
    .clear      (clear),
    .IR75       (IR75),
    .Aeq0       (Aeq0),
    .Apos       (Apos),
    .Enter      (Enter),
    .IRload     (IRload),
    .PCload     (PCload),
    .IMPsel     (IMPsel),
    .MeminstSel (MeminstSel),
    .MemWr      (MemWr),
    .Aload      (Aload),
    .Asel       (Asel),
    .ALUsub     (ALUsub),
    .Halt       (Halt),
    .State      (State)
  );

  always #5 clk = ~clk;

  // Packed view of all control outputs: {IRload,PCload,IMPsel,MeminstSel,MemWr,Aload,Asel,ALUsub,Halt}
  logic [9:0] outs;
  assign outs = {IRload, PCload, IMPsel, MeminstSel, MemWr, Aload, Asel, ALUsub, Halt};

  function automatic logic [9:0] ov(input logic irl, input logic pcl, input logic imp,
                                    input logic mis, input logic mwr, input logic al,
                                    input logic [1:0] as, input logic sub, input logic hlt);
    return {irl, pcl, imp, mis, mwr, al, as, sub, hlt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in FETCH: check FETCH and DECODE, presenting op during DECODE.
  task automatic fetch_decode(input logic [2:0] op);
    chk("fetch_state", State, S_FETCH);
    chk("fetch_outs", outs, ov(1, 1, 0, 0, 0, 0, ASEL_ALU, 0, 0));
    tick();
    IR75 = op;
    #1;
    chk("decode_state", State, S_DECODE);
    chk("decode_outs", outs, ov(0, 0, 0, 1, 0, 0, ASEL_ALU, 0, 0));
    tick();
  endtask

  initial begin
    clear = 1'b1;
    IR75  = 3'b000;
    Aeq0  = 1'b0;
    Apos  = 1'b0;
    Enter = 1'b0;

    // Reset from unknown state
    tick();
    tick();
    chk("reset_state", State, S_START);
    chk("reset_outs", outs, 10'd0);
    clear = 1'b0;
    tick();

    // LOAD
    fetch_decode(OP_LOAD);
    chk("load_state", State, S_LOAD);
    chk("load_outs", outs, ov(0, 0, 0, 1, 0, 1, ASEL_MEM, 0, 0));
    tick();

    // STORE
    fetch_decode(OP_STORE);
    chk("store_state", State, S_STORE);
    chk("store_outs", outs, ov(0, 0, 0, 1, 1, 0, ASEL_ALU, 0, 0));
    tick();

    // ADD
    fetch_decode(OP_ADD);
    chk("add_state", State, S_ADD);
    chk("add_outs", outs, ov(0, 0, 0, 1, 0, 1, ASEL_ALU, 0, 0));
    tick();

    // SUB
    fetch_decode(OP_SUB);
    chk("sub_state", State, S_SUB);
    chk("sub_outs", outs, ov(0, 0, 0, 1, 0, 1, ASEL_ALU, 1, 0));
    tick();

    // JZ taken
    Aeq0 = 1'b1;
    fetch_decode(OP_JZ);
    chk("jz1_state", State, S_JZ);
    chk("jz1_outs", outs, ov(0, 1, 1, 0, 0, 0, ASEL_ALU, 0, 0));
    tick();
    // JZ not taken
    Aeq0 = 1'b0;
    fetch_decode(OP_JZ);
    chk("jz0_outs", outs, ov(0, 0, 1, 0, 0, 0, ASEL_ALU, 0, 0));
    tick();

    // JPOS not taken, then taken
    Apos = 1'b0;
    fetch_decode(OP_JPOS);
    chk("jpos0_state", State, S_JPOS);
    chk("jpos0_outs", outs, ov(0, 0, 1, 0, 0, 0, ASEL_ALU, 0, 0));
    tick();
    Apos = 1'b1;
    fetch_decode(OP_JPOS);
    chk("jpos1_outs", outs, ov(0, 1, 1, 0, 0, 0, ASEL_ALU, 0, 0));
    tick();
    Apos = 1'b0;

    // INPUT with Enter already high on entry
    Enter = 1'b1;
    fetch_decode(OP_INPUT);
    chk("in_hold_state", State, S_INPUT);
    chk("in_hold_outs", outs, ov(0, 0, 0, 0, 0, 0, ASEL_IN, 0, 0));
    tick();
    chk("in_hold2_state", State, S_INPUT);
    Enter = 1'b0;
    #1;
    chk("in_low_outs", outs, ov(0, 0, 0, 0, 0, 0, ASEL_IN, 0, 0));
    tick();
    chk("in_low_state", State, S_INPUT);
    Enter = 1'b1;
    #1;
    chk("in_edge_outs", outs, ov(0, 0, 0, 0, 0, 1, ASEL_IN, 0, 0));
    tick();
    chk("in_after_state", State, S_FETCH);
    chk("in_after_aload", Aload, 1'b0);

    // Clear during INPUT wait
    Enter = 1'b0;
    fetch_decode(OP_INPUT);
    chk("inclr_wait_state", State, S_INPUT);
    clear = 1'b1;
    #1;
    chk("inclr_aload", Aload, 1'b0);
    tick();
    chk("inclr_state", State, S_START);
    chk("inclr_outs", outs, 10'd0);
    clear = 1'b0;
    tick();

    // HALT: parked regardless of Enter and flags
    fetch_decode(OP_HALT);
    for (int i = 0; i < 20; i++) begin
      chk("halt_state", State, S_HALT);
      chk("halt_outs", outs, ov(0, 0, 0, 0, 0, 0, ASEL_ALU, 0, 1));
      Enter = i[0];
      Aeq0  = i[1];
      Apos  = i[2];
      IR75  = i[2:0];
      tick();
    end
    clear = 1'b1;
    tick();
    chk("halt_clr_state", State, S_START);
    chk("halt_clr_halt", Halt, 1'b0);
    clear = 1'b0;
    tick();
    chk("halt_clr_fetch", State, S_FETCH);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
